// File: rtl/fft_stage_feeder_pkg.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | fft_stage_feeder_pkg                                                    |
// | Shared constants, read-FSM encoding and elaboration-time twiddle math.  |
// | Revision: 1.0                                                           |
// +-------------------------------------------------------------------------+
package fft_stage_feeder_pkg;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_EMIT = 2'd1;
    localparam logic [1:0] S_GAP  = 2'd2;

    localparam real C_PI = 3.14159265358979323846;

    function automatic int cplx_width(input int xw);
        return 2 * xw;
    endfunction

    // Twiddle magnitude 1.0 leaves one guard bit below the sign bit.
    function automatic int tw_one(input int xw);
        return 1 << (xw - 2);
    endfunction

    function automatic real taylor_sin(input real x);
        real term;
        real acc;
        term = x;
        acc  = x;
        for (int n = 1; n < 16; n++) begin
            term = -term * x * x / real'((2 * n) * (2 * n + 1));
            acc  = acc + term;
        end
        return acc;
    endfunction

    function automatic real taylor_cos(input real x);
        real term;
        real acc;
        term = 1.0;
        acc  = 1.0;
        for (int n = 1; n < 16; n++) begin
            term = -term * x * x / real'((2 * n - 1) * (2 * n));
            acc  = acc + term;
        end
        return acc;
    endfunction

    function automatic int round_nearest(input real x);
        if (x >= 0.0) begin
            return $rtoi(x + 0.5);
        end
        return -$rtoi(0.5 - x);
    endfunction

    // W = exp(-j*2*pi*t/N): real part is cos, imaginary part is -sin.
    function automatic int tw_re(input int xw, input int logn, input int t);
        real ang;
        ang = 2.0 * C_PI * real'(t) / real'(1 << logn);
        return round_nearest(real'(tw_one(xw)) * taylor_cos(ang));
    endfunction

    function automatic int tw_im(input int xw, input int logn, input int t);
        real ang;
        ang = 2.0 * C_PI * real'(t) / real'(1 << logn);
        return round_nearest(-real'(tw_one(xw)) * taylor_sin(ang));
    endfunction

endpackage
`default_nettype wire

// File: rtl/fft_twiddle_rom.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | fft_twiddle_rom                                                         |
// | Registered twiddle lookup, entries t = 0..N/2-1, built at elaboration.  |
// | Revision: 1.0                                                           |
// +-------------------------------------------------------------------------+
module fft_twiddle_rom
    import fft_stage_feeder_pkg::*;
#(
    parameter int X_WDTH = 16,
    parameter int LOG_N  = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en_i,
    input  logic [LOG_N-2:0]      addr_i,
    output logic [2*X_WDTH-1:0]   w_o
);

    localparam int C_DEPTH = 1 << (LOG_N - 1);

    logic [2*X_WDTH-1:0] rom_w [C_DEPTH];
    logic [2*X_WDTH-1:0] w_q;

    for (genvar t = 0; t < C_DEPTH; t++) begin : g_rom
        localparam int C_RE = tw_re(X_WDTH, LOG_N, t);
        localparam int C_IM = tw_im(X_WDTH, LOG_N, t);
        localparam logic [X_WDTH-1:0] C_RE_W = C_RE[X_WDTH-1:0];
        localparam logic [X_WDTH-1:0] C_IM_W = C_IM[X_WDTH-1:0];
        assign rom_w[t] = {C_RE_W, C_IM_W};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            w_q <= '0;
        end else if (en_i) begin
            w_q <= rom_w[addr_i];
        end
    end

    assign w_o = w_q;

endmodule
`default_nettype wire

// File: rtl/fft_stage_feeder.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | fft_stage_feeder                                                        |
// | Ping-pong buffer feeding radix-2 DIT butterfly pairs every other cycle. |
// | Revision: 1.0                                                           |
// +-------------------------------------------------------------------------+
module fft_stage_feeder
    import fft_stage_feeder_pkg::*;
#(
    parameter int X_WDTH = 16,
    parameter int M_WDTH = 1,
    parameter int LOG_N  = 3,
    parameter int STAGE  = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_nd,
    input  logic [2*X_WDTH-1:0]   in_x,
    input  logic [M_WDTH-1:0]     in_m,
    output logic                  in_ready,
    output logic [2*X_WDTH-1:0]   xa,
    output logic [2*X_WDTH-1:0]   xb,
    output logic [2*X_WDTH-1:0]   w,
    output logic                  x_nd,
    output logic [M_WDTH-1:0]     m_out,
    output logic                  error
);

    localparam int C_CW = cplx_width(X_WDTH);
    localparam int C_N  = 1 << LOG_N;
    localparam int C_PW = LOG_N - 1;
    localparam int C_H  = 1 << STAGE;

    localparam logic [LOG_N-1:0] C_W_LAST = LOG_N'(C_N - 1);
    localparam logic [C_PW-1:0]  C_P_LAST = C_PW'(C_N / 2 - 1);
    localparam logic [C_PW-1:0]  C_KMASK  = C_PW'(C_H - 1);
    localparam logic [LOG_N-1:0] C_HOFF   = LOG_N'(C_H);

    logic [C_CW-1:0]   mem_q [2][C_N];
    logic [M_WDTH-1:0] tag_q [2];

    logic [1:0]       full_q, full_d;
    logic             wr_bank_q, wr_bank_d;
    logic             rd_bank_q, rd_bank_d;
    logic [LOG_N-1:0] wcnt_q, wcnt_d;
    logic [1:0]       state_q, state_d;
    logic [C_PW-1:0]  p_q, p_d;
    logic             error_q, error_d;

    logic [C_CW-1:0]   xa_q, xb_q;
    logic [M_WDTH-1:0] m_q;
    logic              x_nd_q;

    logic              wr_en;
    logic              emit;
    logic [C_PW-1:0]   k_w, g_w, t_w;
    logic [LOG_N-1:0]  a_w, b_w;

    assign in_ready = ~full_q[wr_bank_q];
    assign wr_en    = in_nd & in_ready;
    assign emit     = (state_q == S_EMIT);

    // a = g*2H + k, b = a + H, t = k * N/(2H)
    assign k_w = p_q & C_KMASK;
    assign g_w = p_q >> STAGE;
    assign a_w = (LOG_N'(g_w) << (STAGE + 1)) | LOG_N'(k_w);
    assign b_w = a_w + C_HOFF;
    assign t_w = k_w << (C_PW - STAGE);

    always_comb begin
        full_d    = full_q;
        wr_bank_d = wr_bank_q;
        rd_bank_d = rd_bank_q;
        wcnt_d    = wcnt_q;
        state_d   = state_q;
        p_d       = p_q;
        error_d   = error_q | (in_nd & ~in_ready);

        if (wr_en) begin
            if (wcnt_q == C_W_LAST) begin
                full_d[wr_bank_q] = 1'b1;
                wr_bank_d         = ~wr_bank_q;
                wcnt_d            = '0;
            end else begin
                wcnt_d = wcnt_q + LOG_N'(1);
            end
        end

        // Writer only sets a non-full bank and reader only clears a full one.
        case (state_q)
            S_IDLE: begin
                if (full_q[rd_bank_q]) begin
                    state_d = S_EMIT;
                    p_d     = '0;
                end
            end
            S_EMIT: state_d = S_GAP;
            S_GAP: begin
                if (p_q == C_P_LAST) begin
                    full_d[rd_bank_q] = 1'b0;
                    rd_bank_d         = ~rd_bank_q;
                    state_d           = S_IDLE;
                end else begin
                    p_d     = p_q + C_PW'(1);
                    state_d = S_EMIT;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_bank_q][wcnt_q] <= in_x;
            if (wcnt_q == '0) begin
                tag_q[wr_bank_q] <= in_m;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            full_q    <= '0;
            wr_bank_q <= 1'b0;
            rd_bank_q <= 1'b0;
            wcnt_q    <= '0;
            state_q   <= S_IDLE;
            p_q       <= '0;
            error_q   <= 1'b0;
            xa_q      <= '0;
            xb_q      <= '0;
            m_q       <= '0;
            x_nd_q    <= 1'b0;
        end else begin
            full_q    <= full_d;
            wr_bank_q <= wr_bank_d;
            rd_bank_q <= rd_bank_d;
            wcnt_q    <= wcnt_d;
            state_q   <= state_d;
            p_q       <= p_d;
            error_q   <= error_d;
            x_nd_q    <= emit;
            if (emit) begin
                xa_q <= mem_q[rd_bank_q][a_w];
                xb_q <= mem_q[rd_bank_q][b_w];
                m_q  <= tag_q[rd_bank_q];
            end
        end
    end

    fft_twiddle_rom #(
        .X_WDTH (X_WDTH),
        .LOG_N  (LOG_N)
    ) u_rom (
        .clk    (clk),
        .rst    (rst),
        .en_i   (emit),
        .addr_i (t_w),
        .w_o    (w)
    );

    assign xa    = xa_q;
    assign xb    = xb_q;
    assign m_out = m_q;
    assign x_nd  = x_nd_q;
    assign error = error_q;

endmodule
`default_nettype wire

// File: tb/tb_fft_stage_feeder.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | tb_fft_stage_feeder                                                     |
// | Scoreboard bench driving STAGE 0/1/2 feeders from one shared stream.    |
// | Revision: 1.0                                                           |
// +-------------------------------------------------------------------------+
module tb_fft_stage_feeder;

    typedef struct {
        logic [96:0] v;
        int          cyc;
    } exp_t;

    // Hand-derived pair indices and twiddles for N=8, stages 0..2.
    localparam int A_TAB [3][4]  = '{'{0, 2, 4, 6}, '{0, 1, 4, 5}, '{0, 1, 2, 3}};
    localparam int B_TAB [3][4]  = '{'{1, 3, 5, 7}, '{2, 3, 6, 7}, '{4, 5, 6, 7}};
    localparam int WR_TAB [3][4] = '{'{16384, 16384, 16384, 16384},
                                     '{16384, 0, 16384, 0},
                                     '{16384, 11585, 0, -11585}};
    localparam int WI_TAB [3][4] = '{'{0, 0, 0, 0},
                                     '{0, -16384, 0, -16384},
                                     '{0, -11585, -16384, -11585}};

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_nd = 1'b0;
    logic [31:0] in_x = '0;
    logic [0:0]  in_m = '0;

    logic        in_ready_s [3];
    logic [31:0] xa_s [3];
    logic [31:0] xb_s [3];
    logic [31:0] w_s [3];
    logic        x_nd_s [3];
    logic [0:0]  m_s [3];
    logic        err_s [3];

    exp_t sb [3][$];
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;
    bit   low_seen = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    fft_stage_feeder #(.X_WDTH(16), .M_WDTH(1), .LOG_N(3), .STAGE(0)) u_s0 (
        .clk(clk), .rst(rst), .in_nd(in_nd), .in_x(in_x), .in_m(in_m),
        .in_ready(in_ready_s[0]), .xa(xa_s[0]), .xb(xb_s[0]), .w(w_s[0]),
        .x_nd(x_nd_s[0]), .m_out(m_s[0]), .error(err_s[0]));
    fft_stage_feeder #(.X_WDTH(16), .M_WDTH(1), .LOG_N(3), .STAGE(1)) u_s1 (
        .clk(clk), .rst(rst), .in_nd(in_nd), .in_x(in_x), .in_m(in_m),
        .in_ready(in_ready_s[1]), .xa(xa_s[1]), .xb(xb_s[1]), .w(w_s[1]),
        .x_nd(x_nd_s[1]), .m_out(m_s[1]), .error(err_s[1]));
    fft_stage_feeder #(.X_WDTH(16), .M_WDTH(1), .LOG_N(3), .STAGE(2)) u_s2 (
        .clk(clk), .rst(rst), .in_nd(in_nd), .in_x(in_x), .in_m(in_m),
        .in_ready(in_ready_s[2]), .xa(xa_s[2]), .xb(xb_s[2]), .w(w_s[2]),
        .x_nd(x_nd_s[2]), .m_out(m_s[2]), .error(err_s[2]));

    function automatic logic [31:0] samp(input int f, input int i);
        logic [15:0] re;
        logic [15:0] im;
        re = 16'(f * 256 + i);
        im = 16'(-(f * i));
        return {re, im};
    endfunction

    task automatic check(input string name, input bit ok,
                         input logic [127:0] act, input logic [127:0] req);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s: got %h required %h (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic push_frame(input int f, input logic [0:0] tag, input int e_last, input bit timed);
        exp_t e;
        logic [15:0] wr;
        logic [15:0] wi;
        for (int s = 0; s < 3; s++) begin
            for (int p = 0; p < 4; p++) begin
                wr    = 16'(WR_TAB[s][p]);
                wi    = 16'(WI_TAB[s][p]);
                e.v   = {samp(f, A_TAB[s][p]), samp(f, B_TAB[s][p]), wr, wi, tag};
                e.cyc = timed ? (e_last + 2 + 2 * p) : -1;
                sb[s].push_back(e);
            end
        end
    endtask

    task automatic send_sample(input logic [31:0] x, input logic [0:0] m, output int edge_no);
        int guard;
        guard = 0;
        @(negedge clk);
        while (!in_ready_s[0] && guard < 100) begin
            in_nd    = 1'b0;
            low_seen = 1'b1;
            guard++;
            @(negedge clk);
        end
        if (!in_ready_s[0]) begin
            check("in_ready wait timeout", 1'b0, 128'(in_ready_s[0]), 128'd1);
        end
        in_nd   = 1'b1;
        in_x    = x;
        in_m    = m;
        edge_no = cyc + 1;
        @(posedge clk);
    endtask

    task automatic send_frame(input int f, input logic [0:0] tag, input bit timed);
        int e;
        e = 0;
        for (int i = 0; i < 8; i++) begin
            send_sample(samp(f, i), tag, e);
        end
        push_frame(f, tag, e, timed);
    endtask

    task automatic drain();
        int g;
        g = 0;
        while ((sb[0].size() + sb[1].size() + sb[2].size()) != 0 && g < 300) begin
            @(negedge clk);
            g++;
        end
        check("drain pending pairs", (sb[0].size() + sb[1].size() + sb[2].size()) == 0,
              128'(sb[0].size() + sb[1].size() + sb[2].size()), 128'd0);
        repeat (4) @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int   idx;
        int   dropped;
        int   guard;
        int   e;
        bit   acc;
        bit   prev [3];

        prev = '{0, 0, 0};
        fork
            forever begin
                @(negedge clk);
                for (int s = 0; s < 3; s++) begin
                    if (x_nd_s[s]) begin
                        exp_t ex;
                        check($sformatf("s%0d x_nd adjacent", s), !prev[s], 128'(prev[s]), 128'd0);
                        if (sb[s].size() == 0) begin
                            check($sformatf("s%0d unexpected x_nd", s), 1'b0, 128'(x_nd_s[s]), 128'd0);
                        end else begin
                            ex = sb[s].pop_front();
                            check($sformatf("s%0d pair {xa,xb,w,m}", s),
                                  {xa_s[s], xb_s[s], w_s[s], m_s[s]} == ex.v,
                                  128'({xa_s[s], xb_s[s], w_s[s], m_s[s]}), 128'(ex.v));
                            if (ex.cyc >= 0) begin
                                check($sformatf("s%0d pair cycle", s), cyc == ex.cyc,
                                      128'(cyc), 128'(ex.cyc));
                            end
                        end
                    end
                    prev[s] = x_nd_s[s];
                end
            end
        join_none

        // Reset state
        repeat (3) @(negedge clk);
        check("reset in_ready", in_ready_s[0] == 1'b1, 128'(in_ready_s[0]), 128'd1);
        check("reset error", err_s[0] == 1'b0, 128'(err_s[0]), 128'd0);
        check("reset x_nd", x_nd_s[0] == 1'b0, 128'(x_nd_s[0]), 128'd0);
        check("reset xa/xb/w/m", {xa_s[0], xb_s[0], w_s[0], m_s[0]} == 97'd0,
              128'({xa_s[0], xb_s[0], w_s[0], m_s[0]}), 128'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Single frame re=i, im=0, tag 1: stage 0/1/2 pairings with exact timing
        send_frame(0, 1'b1, 1'b1);
        @(negedge clk);
        in_nd = 1'b0;
        drain();

        // Three back-to-back frames
        low_seen = 1'b0;
        send_frame(1, 1'b0, 1'b0);
        send_frame(2, 1'b1, 1'b0);
        send_frame(3, 1'b0, 1'b0);
        @(negedge clk);
        in_nd = 1'b0;
        drain();
        check("back-pressure seen", low_seen == 1'b1, 128'(low_seen), 128'd1);
        for (int s = 0; s < 3; s++) begin
            check($sformatf("s%0d error after stream", s), err_s[s] == 1'b0, 128'(err_s[s]), 128'd0);
        end

        // Offer samples regardless of in_ready; dropped slots carry a poison word
        send_frame(4, 1'b1, 1'b0);
        send_frame(5, 1'b0, 1'b0);
        idx = 0;
        dropped = 0;
        guard = 0;
        e = 0;
        while (idx < 8 && guard < 100) begin
            @(negedge clk);
            guard++;
            in_nd = 1'b1;
            if (in_ready_s[0]) begin
                in_x = samp(6, idx);
                in_m = 1'b1;
                acc  = 1'b1;
                e    = cyc + 1;
            end else begin
                in_x = 32'hDEAD_BEEF;
                in_m = 1'b0;
                acc  = 1'b0;
                dropped++;
            end
            @(posedge clk);
            if (acc) idx++;
        end
        @(negedge clk);
        in_nd = 1'b0;
        push_frame(6, 1'b1, e, 1'b0);
        check("samples dropped", dropped > 0, 128'(dropped), 128'd1);
        for (int s = 0; s < 3; s++) begin
            check($sformatf("s%0d error set", s), err_s[s] == 1'b1, 128'(err_s[s]), 128'd1);
        end
        drain();
        repeat (20) @(negedge clk);
        check("error sticky", err_s[0] == 1'b1, 128'(err_s[0]), 128'd1);

        // Reset in the middle of a frame
        for (int i = 0; i < 5; i++) begin
            send_sample(samp(7, i), 1'b0, e);
        end
        @(negedge clk);
        in_nd = 1'b0;
        rst   = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int s = 0; s < 3; s++) begin
            check($sformatf("s%0d mid-frame reset in_ready", s), in_ready_s[s] == 1'b1,
                  128'(in_ready_s[s]), 128'd1);
            check($sformatf("s%0d mid-frame reset error", s), err_s[s] == 1'b0,
                  128'(err_s[s]), 128'd0);
        end
        check("mid-frame reset outputs", {xa_s[0], xb_s[0], w_s[0], m_s[0], x_nd_s[0]} == 98'd0,
              128'({xa_s[0], xb_s[0], w_s[0], m_s[0], x_nd_s[0]}), 128'd0);
        repeat (20) @(negedge clk);
        send_frame(8, 1'b1, 1'b1);
        @(negedge clk);
        in_nd = 1'b0;
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
